// File: rtl/nx_stream_pkg.sv
// Shared definitions for the Nexus outbound message stream: message/beat widths,
// keep patterns and the control-flag position.
package nx_stream_pkg;

  localparam int         NX_MSG_WIDTH    = 32;
  localparam int         NX_BEAT_WIDTH   = 64;
  localparam logic [7:0] NX_KEEP_HALF    = 8'h0F;
  localparam logic [7:0] NX_KEEP_FULL    = 8'hFF;
  localparam int         NX_MSG_CTRL_BIT = 31;

  typedef logic [NX_MSG_WIDTH-1:0] nx_msg_t;

endpackage

// File: rtl/nx_idle_timer.sv
// Saturating idle counter: counts enabled cycles up to FLUSH_CYCLES and flags expiry
// while it sits at that limit. Clear has priority over enable.
module nx_idle_timer
  import nx_stream_pkg::*;
#(
  parameter int FLUSH_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(FLUSH_CYCLES);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/nx_axi_ob_packer.sv
// Packs 32-bit outbound messages pairwise into 64-bit AXI4-stream beats; lone words
// leave as half beats on idle timeout or control word. Optional stats: NX_AXI_OB_PACKER_STATS_EN.
//
// state (hold_valid, out_valid) | meaning
// EMPTY                         | no word held; next non-control word is held
// HELD                          | one word held; next accepted word completes a full beat
// (out_valid is orthogonal: a beat is waiting in the output register)
module nx_axi_ob_packer
  import nx_stream_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
  parameter int AXI4_ID_WIDTH   = 1,
  parameter int FLUSH_CYCLES    = 16,
  parameter int MAX_PKT_BEATS   = 64
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [NX_MSG_WIDTH-1:0]    inbound_data_i,
  input  logic                       inbound_valid_i,
  output logic                       inbound_ready_o,
  output logic [AXI4_DATA_WIDTH-1:0] outbound_tdata_o,
  output logic [AXI4_STRB_WIDTH-1:0] outbound_tkeep_o,
  output logic [AXI4_STRB_WIDTH-1:0] outbound_tstrb_o,
  output logic [AXI4_ID_WIDTH-1:0]   outbound_tid_o,
  output logic                       outbound_tlast_o,
  output logic                       outbound_tvalid_o,
`ifdef NX_AXI_OB_PACKER_STATS_EN
  output logic [31:0]                stat_beats_o,
  output logic [31:0]                stat_flushes_o,
`endif
  input  logic                       outbound_tready_i
);

  nx_msg_t                  hold_q;
  logic                     hold_valid_q;
  logic [NX_BEAT_WIDTH-1:0] tdata_q;
  logic [7:0]               tkeep_q;
  logic                     tlast_q;
  logic                     out_valid_q;
  logic [15:0]              pkt_cnt_q;

  logic                     out_free;
  logic                     accept;
  logic                     in_ctrl;
  logic                     expired;
  logic                     flush;
  logic                     max_hit;
  logic                     load;
  logic [NX_BEAT_WIDTH-1:0] beat_data;
  logic [7:0]               beat_keep;
  logic                     beat_last;

  // tready feeds ready combinationally so a stalled beat and a new word can move together
  assign out_free        = !out_valid_q || outbound_tready_i;
  assign inbound_ready_o = out_free;
  assign accept          = inbound_valid_i && out_free;
  assign in_ctrl         = inbound_data_i[NX_MSG_CTRL_BIT];
  assign flush           = hold_valid_q && expired && !accept && out_free;
  assign max_hit         = (pkt_cnt_q == 16'(MAX_PKT_BEATS - 1));

  nx_idle_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_idle_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (accept || !hold_valid_q),
    .en_i     (hold_valid_q && !accept),
    .expired_o(expired)
  );

  always_comb begin
    load      = 1'b0;
    beat_data = '0;
    beat_keep = NX_KEEP_HALF;
    beat_last = 1'b1;
    if (accept && hold_valid_q) begin
      load      = 1'b1;
      beat_data = {inbound_data_i, hold_q};
      beat_keep = NX_KEEP_FULL;
      beat_last = in_ctrl || max_hit;
    end else if (accept && in_ctrl) begin
      load      = 1'b1;
      beat_data = {{NX_MSG_WIDTH{1'b0}}, inbound_data_i};
    end else if (flush) begin
      load      = 1'b1;
      beat_data = {{NX_MSG_WIDTH{1'b0}}, hold_q};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (accept) begin
      if (hold_valid_q) begin
        hold_valid_q <= 1'b0;
      end else if (!in_ctrl) begin
        hold_q       <= inbound_data_i;
        hold_valid_q <= 1'b1;
      end
    end else if (flush) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Beats are numbered as they are loaded; with one beat in flight this matches handshake order
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      out_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else if (load) begin
      tdata_q     <= beat_data;
      tkeep_q     <= beat_keep;
      tlast_q     <= beat_last;
      out_valid_q <= 1'b1;
      pkt_cnt_q   <= beat_last ? 16'd0 : pkt_cnt_q + 16'd1;
    end else if (out_free) begin
      out_valid_q <= 1'b0;
    end
  end

  assign outbound_tdata_o  = tdata_q;
  assign outbound_tkeep_o  = tkeep_q;
  assign outbound_tstrb_o  = tkeep_q;
  assign outbound_tlast_o  = tlast_q;
  assign outbound_tvalid_o = out_valid_q;
  assign outbound_tid_o    = '0;

`ifdef NX_AXI_OB_PACKER_STATS_EN
  logic [31:0] stat_beats_q;
  logic [31:0] stat_flushes_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stat_beats_q   <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (out_valid_q && outbound_tready_i) stat_beats_q <= stat_beats_q + 32'd1;
      if (flush) stat_flushes_q <= stat_flushes_q + 32'd1;
    end
  end

  assign stat_beats_o   = stat_beats_q;
  assign stat_flushes_o = stat_flushes_q;
`endif

endmodule

// File: tb/tb_nx_axi_ob_packer.sv
// Self-checking bench for nx_axi_ob_packer: word-level reference model compared every
// cycle, an accepted-word scoreboard, and directed cases with literal expectations.
module tb_nx_axi_ob_packer;

  localparam int FLUSH = 16;
  localparam int MAXB  = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [7:0]  tstrb;
  logic [0:0]  tid;
  logic        tlast;
  logic        tvalid;
  logic        tready = 1'b1;
`ifdef NX_AXI_OB_PACKER_STATS_EN
  logic [31:0] stat_beats;
  logic [31:0] stat_flushes;
`endif

  always #5 clk = ~clk;

  nx_axi_ob_packer #(
    .FLUSH_CYCLES (FLUSH),
    .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .inbound_data_i   (in_data),
    .inbound_valid_i  (in_valid),
    .inbound_ready_o  (in_ready),
    .outbound_tdata_o (tdata),
    .outbound_tkeep_o (tkeep),
    .outbound_tstrb_o (tstrb),
    .outbound_tid_o   (tid),
    .outbound_tlast_o (tlast),
    .outbound_tvalid_o(tvalid),
`ifdef NX_AXI_OB_PACKER_STATS_EN
    .stat_beats_o     (stat_beats),
    .stat_flushes_o   (stat_flushes),
`endif
    .outbound_tready_i(tready)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Reference model: pending beat, held word, idle count, packet position.
  logic        m_ov, m_hv, m_last, ld, lx, free, acc;
  logic [63:0] m_data, dx;
  logic [7:0]  m_keep, kx;
  logic [31:0] m_hold;
  int          m_idle, m_pkt;
  int unsigned m_beats, m_flushes;
  logic [31:0] sb[$];

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_ov = 0; m_hv = 0; m_last = 0; m_data = '0; m_keep = '0; m_hold = '0;
      m_idle = 0; m_pkt = 0; m_beats = 0; m_flushes = 0;
      sb.delete();
    end else begin
      free = !m_ov || tready;
      acc  = in_valid && free;
      ld   = 0; dx = '0; kx = '0; lx = 0;
      if (m_ov && tready) begin
        m_beats++;
        m_ov = 0;
      end
      if (acc) begin
        sb.push_back(in_data);
        if (m_hv) begin
          ld = 1; dx = {in_data, m_hold}; kx = 8'hFF;
          lx = in_data[31] || (m_pkt + 1 == MAXB);
          m_hv = 0;
        end else if (in_data[31]) begin
          ld = 1; dx = {32'h0, in_data}; kx = 8'h0F; lx = 1;
        end else begin
          m_hold = in_data; m_hv = 1;
        end
        m_idle = 0;
      end else if (m_hv) begin
        if (m_idle >= FLUSH && free) begin
          ld = 1; dx = {32'h0, m_hold}; kx = 8'h0F; lx = 1;
          m_hv = 0; m_idle = 0; m_flushes++;
        end else if (m_idle < FLUSH) begin
          m_idle++;
        end
      end
      if (ld) begin
        m_ov = 1; m_data = dx; m_keep = kx; m_last = lx;
        m_pkt = lx ? 0 : m_pkt + 1;
      end
    end
  end

  int          hs_cnt = 0, last_cnt = 0, tv_cnt = 0;
  logic [31:0] w;

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("tvalid", 64'(tvalid), 64'(m_ov));
      chk("in_ready", 64'(in_ready), 64'(!m_ov || tready));
      chk("tid", 64'(tid), 64'(0));
      if (m_ov) begin
        chk("tdata", tdata, m_data);
        chk("tkeep", 64'(tkeep), 64'(m_keep));
        chk("tstrb", 64'(tstrb), 64'(m_keep));
        chk("tlast", 64'(tlast), 64'(m_last));
      end
`ifdef NX_AXI_OB_PACKER_STATS_EN
      chk("stat_beats", 64'(stat_beats), 64'(m_beats));
      chk("stat_flushes", 64'(stat_flushes), 64'(m_flushes));
`endif
      if (tvalid) tv_cnt++;
      if (tvalid && tready) begin
        hs_cnt++;
        if (tlast) last_cnt++;
        chk("sb_avail", 64'(sb.size() >= ((tkeep == 8'hFF) ? 2 : 1)), 64'(1));
        if (sb.size() > 0) begin
          w = sb.pop_front();
          chk("sb_low", 64'(tdata[31:0]), 64'(w));
        end
        if (tkeep == 8'hFF) begin
          if (sb.size() > 0) begin
            w = sb.pop_front();
            chk("sb_high", 64'(tdata[63:32]), 64'(w));
          end
        end else begin
          chk("sb_half_hi", 64'(tdata[63:32]), 64'(0));
        end
      end
    end
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  task send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task mid_reset;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tdata", tdata, 64'(0));
    chk("rst_tkeep", 64'(tkeep), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
`ifdef NX_AXI_OB_PACKER_STATS_EN
    chk("rst_stat_beats", 64'(stat_beats), 64'(0));
    chk("rst_stat_flushes", 64'(stat_flushes), 64'(0));
`endif
    @(negedge clk);
    rstn   = 1'b1;
    tready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int   hs0, tv0, l0, fl_k, early, idx, c, rdy_low;
  logic a;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("reset_tvalid", 64'(tvalid), 64'(0));
    chk("reset_ready", 64'(in_ready), 64'(1));
    chk("reset_tdata", tdata, 64'(0));
    chk("reset_tkeep", 64'(tkeep), 64'(0));
    chk("reset_tlast", 64'(tlast), 64'(0));

    // idle: nothing may appear
    tv0 = tv_cnt;
    repeat (100) step();
    chk("idle_no_tvalid", 64'(tv_cnt - tv0), 64'(0));

    // pair, visible one cycle after second accept
    send(32'h0000_0011);
    send(32'h0000_0022);
    chk("pair_tvalid", 64'(tvalid), 64'(1));
    chk("pair_tdata", tdata, 64'h0000_0022_0000_0011);
    chk("pair_tkeep", 64'(tkeep), 64'(8'hFF));
    chk("pair_tlast", 64'(tlast), 64'(0));
    repeat (2) step();

    // lone word flushes once 16 idle cycles have been counted
    send(32'h0000_0005);
    fl_k = 0;
    do begin
      step();
      fl_k++;
    end while (!tvalid && fl_k < 40);
    chk("flush_latency", 64'(fl_k), 64'(FLUSH + 1));
    chk("flush_tdata", tdata, 64'h0000_0000_0000_0005);
    chk("flush_tkeep", 64'(tkeep), 64'(8'h0F));
    chk("flush_tlast", 64'(tlast), 64'(1));
    chk("model_flushes", 64'(m_flushes), 64'(1));
    repeat (2) step();

    // word arriving in the expiry cycle pairs instead of flushing
    send(32'h0000_0005);
    early = 0;
    repeat (FLUSH) begin
      step();
      if (tvalid) early++;
    end
    send(32'h0000_0006);
    chk("race_no_flush", 64'(early), 64'(0));
    chk("race_tdata", tdata, 64'h0000_0006_0000_0005);
    chk("race_tkeep", 64'(tkeep), 64'(8'hFF));
    chk("race_tlast", 64'(tlast), 64'(0));
    repeat (2) step();

    // control words
    send(32'h8000_0001);
    chk("ctrl_half_tdata", tdata, 64'h0000_0000_8000_0001);
    chk("ctrl_half_tkeep", 64'(tkeep), 64'(8'h0F));
    chk("ctrl_half_tlast", 64'(tlast), 64'(1));
    step();
    send(32'h0000_0007);
    chk("ctrl_held_no_beat", 64'(tvalid), 64'(0));
    send(32'h8000_0002);
    chk("ctrl_full_tdata", tdata, 64'h8000_0002_0000_0007);
    chk("ctrl_full_tkeep", 64'(tkeep), 64'(8'hFF));
    chk("ctrl_full_tlast", 64'(tlast), 64'(1));
    repeat (2) step();

    // 64-word stream with a 20-cycle tready stall
    hs0 = hs_cnt; l0 = last_cnt; idx = 0; c = 0; rdy_low = 0;
    while (idx < 64 && c < 300) begin
      tready   = !(c >= 10 && c < 30);
      in_valid = 1'b1;
      in_data  = 32'h0000_0100 + 32'(idx);
      @(negedge clk);
      a = in_ready;
      if (!a) rdy_low++;
      step();
      if (a) idx++;
      c++;
    end
    in_valid = 1'b0;
    tready   = 1'b1;
    repeat (5) step();
    chk("stream_words", 64'(idx), 64'(64));
    chk("stream_ready_low", 64'(rdy_low > 0), 64'(1));
    chk("stream_beats", 64'(hs_cnt - hs0), 64'(32));
    chk("stream_tlasts", 64'(last_cnt - l0), 64'(8));
    chk("stream_sb_drained", 64'(sb.size()), 64'(0));

    // reset with a stalled beat, then with a held word
    tready = 1'b0;
    send(32'h0000_0041);
    send(32'h0000_0042);
    chk("stall_tvalid", 64'(tvalid), 64'(1));
    chk("stall_ready", 64'(in_ready), 64'(0));
    repeat (3) step();
    mid_reset();
    step();
    send(32'h0000_0043);
    step();
    mid_reset();
    step();
    send(32'h0000_0051);
    send(32'h0000_0052);
    chk("post_rst_tvalid", 64'(tvalid), 64'(1));
    chk("post_rst_tdata", tdata, 64'h0000_0052_0000_0051);
    chk("post_rst_tkeep", 64'(tkeep), 64'(8'hFF));
    chk("post_rst_tlast", 64'(tlast), 64'(0));
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
